// File: rtl/serial_add_seq_pkg.sv
// Shared definitions for the bit-serial add/subtract sequencer and the ALU
// control that will drive it: FSM state encoding and operation select codes.
package serial_add_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Two's complement overflow: carry into the MSB differs from carry out of it.
  function automatic logic signed_ovf(input logic c_msb_in, input logic c_msb_out);
    return c_msb_in ^ c_msb_out;
  endfunction

endpackage

// File: rtl/serial_add_seq_if.sv
// Start/busy/done handshake and operand/result bus of the serial adder.
interface serial_add_seq_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             op_sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             overflow;

  modport master (
    output start, op_sub, a, b,
    input  busy, done, result, carry_out, overflow
  );

  modport slave (
    input  start, op_sub, a, b,
    output busy, done, result, carry_out, overflow
  );
endinterface

// File: rtl/bit_adder.sv
// Existing one-bit full adder used as the serial datapath.
module bit_adder (
  output logic sum,
  output logic carryout,
  input  logic in1,
  input  logic in2,
  input  logic carryin
);
  assign sum      = in1 ^ in2 ^ carryin;
  assign carryout = (in1 & in2) | (in1 & carryin) | (in2 & carryin);
endmodule

// File: rtl/serial_add_seq.sv
// Bit-serial add/subtract sequencer: feeds one bit pair per cycle (LSB first)
// through a single bit_adder, keeping the carry in a flop and shifting the
// sum bits into the result register from the MSB end.
module serial_add_seq
  import serial_add_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic            clk,
  input  logic            reset,
  serial_add_seq_if.slave bus
);

  localparam int              CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state_r;
  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] b_sh_r;
  logic [WIDTH-1:0] result_r;
  logic [CNT_W-1:0] cnt_r;
  logic             carry_r;
  logic             carry_out_r;
  logic             overflow_r;
  logic             busy_r;
  logic             done_r;
  logic             sum_s;
  logic             cout_s;

  bit_adder u_bit_adder (
    .sum      (sum_s),
    .carryout (cout_s),
    .in1      (a_sh_r[0]),
    .in2      (b_sh_r[0]),
    .carryin  (carry_r)
  );

  // Sequencer FSM with datapath shift registers and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      a_sh_r      <= {WIDTH{1'b0}};
      b_sh_r      <= {WIDTH{1'b0}};
      result_r    <= {WIDTH{1'b0}};
      cnt_r       <= {CNT_W{1'b0}};
      carry_r     <= 1'b0;
      carry_out_r <= 1'b0;
      overflow_r  <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            a_sh_r   <= bus.a;
            // Subtraction is a + ~b + 1: invert b and seed the carry with 1.
            b_sh_r   <= (bus.op_sub == OP_SUB) ? ~bus.b : bus.b;
            carry_r  <= bus.op_sub;
            cnt_r    <= {CNT_W{1'b0}};
            result_r <= {WIDTH{1'b0}};
            busy_r   <= 1'b1;
            state_r  <= RUN;
          end else begin
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end
        end
        RUN: begin
          result_r <= {sum_s, result_r[WIDTH-1:1]};
          a_sh_r   <= {1'b0, a_sh_r[WIDTH-1:1]};
          b_sh_r   <= {1'b0, b_sh_r[WIDTH-1:1]};
          carry_r  <= cout_s;
          cnt_r    <= cnt_r + CNT_ONE;
          if (cnt_r == LAST_CNT) begin
            // carry_r here is the carry into the MSB position.
            carry_out_r <= cout_s;
            overflow_r  <= signed_ovf(carry_r, cout_s);
            busy_r      <= 1'b0;
            done_r      <= 1'b1;
            state_r     <= DONE;
          end else begin
            busy_r  <= 1'b1;
            done_r  <= 1'b0;
            state_r <= RUN;
          end
        end
        DONE: begin
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.result    = result_r;
  assign bus.carry_out = carry_out_r;
  assign bus.overflow  = overflow_r;

endmodule

// File: tb/tb_serial_add_seq.sv
// Self-checking bench for serial_add_seq: directed and random add/sub
// operations, start-during-run and mid-run reset corners. Expected results
// come from plain integer arithmetic and are checked by a done-driven monitor.
module tb_serial_add_seq;
  import serial_add_seq_pkg::*;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] res;
    logic         cout;
    logic         ovf;
  } exp_t;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fails;
  exp_t sb_q[$];

  serial_add_seq_if #(.WIDTH(W)) bus();

  serial_add_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: modular result, unsigned carry/no-borrow and signed range test.
  function automatic exp_t model(input logic op, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t m;
    int ux, uy, sx, sy, full, sfull;
    ux = int'(x);
    uy = int'(y);
    sx = int'($signed(x));
    sy = int'($signed(y));
    if (op == OP_SUB) begin
      full   = ux - uy;
      sfull  = sx - sy;
      m.cout = (ux >= uy);
    end else begin
      full   = ux + uy;
      sfull  = sx + sy;
      m.cout = (full >= (1 << W));
    end
    m.res = W'(full);
    m.ovf = (sfull > ((1 << (W - 1)) - 1)) || (sfull < -(1 << (W - 1)));
    return m;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("result", 32'(bus.result), 32'(e.res));
        check("carry_out", 32'(bus.carry_out), 32'(e.cout));
        check("overflow", 32'(bus.overflow), 32'(e.ovf));
      end
    end
  end

  // Issue one operation; optionally pulse start with other operands mid-run.
  task automatic do_op(input logic op, input logic [W-1:0] x, input logic [W-1:0] y,
                       input bit inject);
    int lat;
    int busy_cnt;
    @(negedge clk);
    bus.start  = 1'b1;
    bus.op_sub = op;
    bus.a      = x;
    bus.b      = y;
    sb_q.push_back(model(op, x, y));
    @(posedge clk);
    #1;
    bus.start  = 1'b0;
    bus.a      = W'($urandom);
    bus.b      = W'($urandom);
    bus.op_sub = 1'($urandom);
    lat      = 0;
    busy_cnt = 0;
    while (bus.done !== 1'b1 && lat < 4 * W) begin
      if (bus.busy === 1'b1) busy_cnt++;
      if (inject && lat == 3) begin
        bus.start = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk);
      #1;
      lat++;
    end
    bus.start = 1'b0;
    check("done_latency", 32'(lat), 32'(W));
    check("busy_cycles", 32'(busy_cnt), 32'(W));
    @(posedge clk);
    #1;
    check("done_one_cycle", 32'(bus.done), 32'd0);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_done"}, 32'(bus.done), 32'd0);
    check({tag, "_result"}, 32'(bus.result), 32'd0);
    check({tag, "_carry_out"}, 32'(bus.carry_out), 32'd0);
    check({tag, "_overflow"}, 32'(bus.overflow), 32'd0);
  endtask

  initial begin
    n_checks   = 0;
    n_fails    = 0;
    reset      = 1'b1;
    bus.start  = 1'b0;
    bus.op_sub = OP_ADD;
    bus.a      = {W{1'b0}};
    bus.b      = {W{1'b0}};
    repeat (3) @(posedge clk);
    #1;
    check_zero_outputs("reset");
    reset = 1'b0;

    // Directed arithmetic corners.
    do_op(OP_ADD, 8'h35, 8'h4A, 1'b0);
    do_op(OP_ADD, 8'hFF, 8'h01, 1'b0);
    do_op(OP_ADD, 8'h7F, 8'h01, 1'b0);
    do_op(OP_SUB, 8'h10, 8'h20, 1'b0);
    do_op(OP_SUB, 8'h80, 8'h01, 1'b0);

    // Results hold after done until the next accepted start.
    repeat (3) @(posedge clk);
    #1;
    check("hold_result", 32'(bus.result), 32'h7F);
    check("hold_carry_out", 32'(bus.carry_out), 32'd1);
    check("hold_overflow", 32'(bus.overflow), 32'd1);

    // Start pulsed during RUN must be ignored.
    do_op(OP_ADD, 8'h12, 8'h34, 1'b1);
    check("no_extra_busy", 32'(bus.busy), 32'd0);

    // Reset in the 4th RUN cycle discards the operation.
    @(negedge clk);
    bus.start  = 1'b1;
    bus.op_sub = OP_ADD;
    bus.a      = 8'h55;
    bus.b      = 8'h22;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_zero_outputs("midrun_reset");
    repeat (W + 2) @(posedge clk);
    #1;
    check("abort_no_done", 32'(sb_q.size()), 32'd0);
    do_op(OP_ADD, 8'h01, 8'h01, 1'b0);

    // Random operations.
    for (int i = 0; i < 24; i++) begin
      do_op(1'($urandom), W'($urandom), W'($urandom), ($urandom_range(0, 3) == 0));
    end

    repeat (2) @(posedge clk);
    #1;
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
